// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, direction and size codes, IO window.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'b00,
    STATE_LS_RD = 2'b01,
    STATE_LS_WR = 2'b10,
    STATE_IF_RD = 2'b11
  } state_e;

  localparam logic RAM_LOAD  = 1'b0;
  localparam logic RAM_STORE = 1'b1;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // Anything other than a byte or halfword transfers a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_H: return size;
      default:        return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: fixed-priority load/store over fetch, one byte per cycle,
// little-endian assembly, rollback flush of reads and IO back-pressure on writes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ls_en,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [2:0]        ls_size,
  input  logic              ls_wr,
  output logic              ls_finish,
  output logic [31:0]       ls_rdata,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_finish,
  output logic [31:0]       if_inst,
  input  logic              rollback,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_e            state, state_nxt;
  logic [2:0]        cnt, len;
  logic [ADDR_W-1:0] base, cur_addr;
  logic [31:0]       wbuf, asm_q, rd_word, ls_rdata_q, if_inst_q;

  logic              ls_pend_v, ls_pend_wr;
  logic [2:0]        ls_pend_size;
  logic [ADDR_W-1:0] ls_pend_addr;
  logic [31:0]       ls_pend_wdata;
  logic              if_pend_v;
  logic [ADDR_W-1:0] if_pend_addr;

  logic              ls_take, if_take, ls_req_v, if_req_v, ls_req_wr;
  logic [2:0]        ls_req_size;
  logic [ADDR_W-1:0] ls_req_addr, if_req_addr;
  logic [31:0]       ls_req_wdata;

  logic              start_ls, start_if, step, wr_c, io_stall;
  logic              ls_rd_done, if_rd_done, ls_wr_done;

  // A same-cycle pulse is visible to arbitration directly; rollback filters out loads and fetches.
  always_comb begin
    ls_take      = ls_en && (!rollback || ls_wr == RAM_STORE);
    if_take      = if_en && !rollback;
    ls_req_v     = ls_take || (ls_pend_v && !(rollback && ls_pend_wr == RAM_LOAD));
    if_req_v     = if_take || (if_pend_v && !rollback);
    ls_req_wr    = ls_take ? ls_wr    : ls_pend_wr;
    ls_req_size  = ls_take ? ls_size  : ls_pend_size;
    ls_req_addr  = ls_take ? ls_addr  : ls_pend_addr;
    ls_req_wdata = ls_take ? ls_wdata : ls_pend_wdata;
    if_req_addr  = if_take ? if_addr  : if_pend_addr;
  end

  assign cur_addr = base + ADDR_W'(cnt);
  assign io_stall = io_buffer_full && (cur_addr[17:16] == IO_SEL);

  // Byte cnt-1 arrives on mem_din this cycle; merge it so the finish cycle sees the full word.
  always_comb begin
    rd_word = asm_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (cnt != 3'd0 && (cnt - 3'd1) == 3'(b)) rd_word[8*b +: 8] = mem_din;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_ls   = 1'b0;
    start_if   = 1'b0;
    step       = 1'b0;
    wr_c       = 1'b0;
    ls_rd_done = 1'b0;
    if_rd_done = 1'b0;
    ls_wr_done = 1'b0;
    mem_a      = '0;
    mem_dout   = '0;
    case (state)
      STATE_IDLE: begin
        if (ls_req_v) begin
          start_ls  = 1'b1;
          state_nxt = (ls_req_wr == RAM_STORE) ? STATE_LS_WR : STATE_LS_RD;
        end else if (if_req_v) begin
          start_if  = 1'b1;
          state_nxt = STATE_IF_RD;
        end
      end
      STATE_LS_RD, STATE_IF_RD: begin
        if (cnt == len) begin
          ls_rd_done = (state == STATE_LS_RD) && !rollback;
          if_rd_done = (state == STATE_IF_RD) && !rollback;
          state_nxt  = STATE_IDLE;
        end else begin
          mem_a = cur_addr;
          step  = 1'b1;
        end
        if (rollback) state_nxt = STATE_IDLE;
      end
      STATE_LS_WR: begin
        if (cnt == len) begin
          ls_wr_done = 1'b1;
          state_nxt  = STATE_IDLE;
        end else begin
          mem_a    = cur_addr;
          mem_dout = wbuf[{cnt[1:0], 3'b000} +: 8];
          if (!io_stall) begin
            wr_c = 1'b1;
            step = 1'b1;
          end
        end
      end
    endcase
  end

  assign mem_wr    = wr_c && rdy;
  assign ls_finish = (ls_rd_done || ls_wr_done) && rdy;
  assign if_finish = if_rd_done && rdy;
  assign ls_rdata  = (ls_rd_done && rdy) ? rd_word : ls_rdata_q;
  assign if_inst   = (if_rd_done && rdy) ? rd_word : if_inst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= STATE_IDLE;
      cnt           <= '0;
      len           <= '0;
      base          <= '0;
      wbuf          <= '0;
      asm_q         <= '0;
      ls_rdata_q    <= '0;
      if_inst_q     <= '0;
      ls_pend_v     <= 1'b0;
      ls_pend_wr    <= 1'b0;
      ls_pend_size  <= '0;
      ls_pend_addr  <= '0;
      ls_pend_wdata <= '0;
      if_pend_v     <= 1'b0;
      if_pend_addr  <= '0;
    end else if (rdy) begin
      state <= state_nxt;

      if (start_ls) begin
        ls_pend_v <= 1'b0;
      end else if (ls_take) begin
        ls_pend_v     <= 1'b1;
        ls_pend_wr    <= ls_wr;
        ls_pend_size  <= ls_size;
        ls_pend_addr  <= ls_addr;
        ls_pend_wdata <= ls_wdata;
      end else if (rollback && ls_pend_wr == RAM_LOAD) begin
        ls_pend_v <= 1'b0;
      end

      if (start_if) begin
        if_pend_v <= 1'b0;
      end else if (if_take) begin
        if_pend_v    <= 1'b1;
        if_pend_addr <= if_addr;
      end else if (rollback) begin
        if_pend_v <= 1'b0;
      end

      if (start_ls) begin
        base  <= ls_req_addr;
        len   <= norm_size(ls_req_size);
        wbuf  <= ls_req_wdata;
        cnt   <= '0;
        asm_q <= '0;
      end else if (start_if) begin
        base  <= if_req_addr;
        len   <= SIZE_W;
        cnt   <= '0;
        asm_q <= '0;
      end else begin
        if (step) cnt <= cnt + 3'd1;
        if (state == STATE_LS_RD || state == STATE_IF_RD) asm_q <= rd_word;
      end

      if (ls_rd_done) ls_rdata_q <= rd_word;
      if (if_rd_done) if_inst_q  <= rd_word;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios followed by randomized traffic
// checked against a byte-array memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, ls_en, ls_wr, if_en, rollback, io_buffer_full;
  logic        ls_finish, if_finish, mem_wr;
  logic [31:0] ls_addr, ls_wdata, ls_rdata, if_addr, if_inst, mem_a;
  logic [2:0]  ls_size;
  logic [7:0]  mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ls_en(ls_en), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_size(ls_size), .ls_wr(ls_wr),
    .ls_finish(ls_finish), .ls_rdata(ls_rdata),
    .if_en(if_en), .if_addr(if_addr), .if_finish(if_finish), .if_inst(if_inst),
    .rollback(rollback), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  typedef struct { bit wr; logic [31:0] data; } ls_exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_exp_t;

  ls_exp_t     ls_q[$];
  logic [31:0] if_q[$];
  wr_exp_t     wr_q[$];
  logic [7:0]  dev_mem[logic [31:0]];
  logic [7:0]  ref_mem[logic [31:0]];
  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[23:16] ^ a[7:0];
  endfunction

  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int unsigned eff_size(input logic [2:0] s);
    return (s == 3'd1 || s == 3'd2 || s == 3'd4) ? int'(s) : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = ref_rd(addr + 32'(i));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // RAM device: data for an address appears one cycle later; writes land on the clock edge.
  always @(posedge clk) begin
    mem_din <= dev_rd(mem_a);
    if (rst && mem_wr) dev_mem[mem_a] = mem_dout;
  end

  always @(negedge clk) begin
    if (rst) begin
      ls_exp_t e;
      wr_exp_t w;
      if (ls_finish || if_finish) check("single_finish", {31'b0, ls_finish && if_finish}, 32'd0);
      if (ls_finish) begin
        check("ls_finish_expected", {31'b0, ls_finish}, {31'b0, ls_q.size() != 0});
        if (ls_q.size() != 0) begin
          e = ls_q.pop_front();
          if (!e.wr) check("ls_rdata", ls_rdata, e.data);
        end
      end
      if (if_finish) begin
        check("if_finish_expected", {31'b0, if_finish}, {31'b0, if_q.size() != 0});
        if (if_q.size() != 0) check("if_inst", if_inst, if_q.pop_front());
      end
      if (mem_wr) begin
        check("io_stall_respected", {31'b0, io_buffer_full && mem_a[17:16] == 2'b11}, 32'd0);
        check("write_expected", {31'b0, mem_wr}, {31'b0, wr_q.size() != 0});
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("write_addr", mem_a, w.addr);
          check("write_data", {24'b0, mem_dout}, {24'b0, w.data});
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ls_en    = 1'b0;
    if_en    = 1'b0;
    rollback = 1'b0;
  endtask

  task automatic issue_ls(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input bit rb);
    int unsigned n;
    ls_exp_t e;
    wr_exp_t w;
    n        = eff_size(size);
    ls_en    = 1'b1;
    ls_wr    = wr;
    ls_size  = size;
    ls_addr  = addr;
    ls_wdata = data;
    if (wr) begin
      for (int unsigned i = 0; i < n; i++) begin
        w.addr = addr + 32'(i);
        w.data = data[8*i +: 8];
        ref_mem[w.addr] = w.data;
        wr_q.push_back(w);
      end
      e.wr = 1'b1; e.data = '0;
      ls_q.push_back(e);
    end else if (!rb) begin
      e.wr = 1'b0; e.data = ref_load(addr, n);
      ls_q.push_back(e);
    end
  endtask

  task automatic issue_if(input logic [31:0] addr, input bit rb);
    if_en   = 1'b1;
    if_addr = addr;
    if (!rb) if_q.push_back(ref_load(addr, 4));
  endtask

  // Rollback cancels every load and fetch not yet finished; stores survive.
  task automatic do_rollback();
    rollback = 1'b1;
    for (int i = int'(ls_q.size()) - 1; i >= 0; i--) if (!ls_q[i].wr) ls_q.delete(i);
    if_q.delete();
  endtask

  initial begin
    bit          rb, wr;
    logic [2:0]  size;
    logic [31:0] addr;
    int unsigned r;

    rst = 1'b0; rdy = 1'b1; ls_en = 1'b0; if_en = 1'b0; rollback = 1'b0; io_buffer_full = 1'b0;
    ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0; if_addr = '0;
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h201, 8'hAA); preload(32'h202, 8'hBB);

    @(negedge clk);
    check("rst_ls_finish", {31'b0, ls_finish}, 32'd0);
    check("rst_if_finish", {31'b0, if_finish}, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    #2 rst = 1'b1;

    // LW 0x100: address per cycle, finish 5 cycles after the request
    tick(); issue_ls(1'b0, 3'd4, 32'h100, '0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(); @(negedge clk);
      if (k <= 4) check("lw_addr", mem_a, 32'h100 + 32'(k - 1));
      check("lw_finish", {31'b0, ls_finish}, {31'b0, k == 5});
      if (k >= 5) check("lw_rdata", ls_rdata, 32'h44332211);
    end

    // LH 0x201
    tick(); issue_ls(1'b0, 3'd2, 32'h201, '0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(); @(negedge clk);
      check("lh_addr", mem_a, (k <= 2) ? 32'h200 + 32'(k) : 32'h0);
      check("lh_finish", {31'b0, ls_finish}, {31'b0, k == 3});
      if (k == 3) check("lh_rdata", ls_rdata, 32'h0000BBAA);
    end

    // SW to the IO window with a 3-cycle stall after byte 0
    tick(); issue_ls(1'b1, 3'd4, 32'h30000, 32'hDEADBEEF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(); io_buffer_full = (k >= 2 && k <= 4); @(negedge clk);
      check("sw_mem_wr", {31'b0, mem_wr}, {31'b0, k == 1 || (k >= 5 && k <= 7)});
      check("sw_finish", {31'b0, ls_finish}, {31'b0, k == 8});
    end
    io_buffer_full = 1'b0;

    // SB frozen by rdy for two cycles
    tick(); issue_ls(1'b1, 3'd1, 32'h2000, 32'h5A, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(); rdy = (k >= 3); @(negedge clk);
      check("rdy_mem_wr", {31'b0, mem_wr}, {31'b0, k == 3});
      check("rdy_finish", {31'b0, ls_finish}, {31'b0, k == 4});
    end

    // Simultaneous LB and fetch: load first, one idle bubble, then fetch
    tick(); issue_ls(1'b0, 3'd1, 32'h40, '0, 1'b0); issue_if(32'h1000, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick(); @(negedge clk);
      check("dual_ls_finish", {31'b0, ls_finish}, {31'b0, k == 2});
      check("dual_if_finish", {31'b0, if_finish}, {31'b0, k == 8});
      if (k >= 3 && k <= 7) check("dual_addr", mem_a, (k == 3) ? 32'h0 : 32'h1000 + 32'(k - 4));
    end

    // Rollback mid-fetch with a load pending, then an SB issued alongside a rollback
    tick(); issue_if(32'h1000, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) issue_ls(1'b0, 3'd4, 32'h100, '0, 1'b0);
      if (k == 3) do_rollback();
      if (k == 5) begin do_rollback(); issue_ls(1'b1, 3'd1, 32'h2001, 32'hC3, 1'b1); end
      @(negedge clk);
      check("rb_if_finish", {31'b0, if_finish}, 32'd0);
      if (k == 4 || k == 5) check("rb_idle_addr", mem_a, 32'h0);
      if (k >= 4) check("rb_sb_write", {31'b0, mem_wr}, {31'b0, k == 6});
      if (k >= 4) check("rb_sb_finish", {31'b0, ls_finish}, {31'b0, k == 7});
    end

    // Asynchronous reset in the middle of a store
    tick(); issue_ls(1'b1, 3'd4, 32'h50000, 32'h01020304, 1'b0);
    tick(); tick(); @(negedge clk);
    check("pre_rst_mem_wr", {31'b0, mem_wr}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("async_rst_mem_a", mem_a, 32'd0);
    check("async_rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    check("async_rst_ls_rdata", ls_rdata, 32'd0);
    check("async_rst_ls_finish", {31'b0, ls_finish}, 32'd0);
    ls_q.delete(); wr_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick(); issue_ls(1'b0, 3'd4, 32'h100, '0, 1'b0);
    repeat (7) tick();
    check("post_rst_lw_done", 32'(ls_q.size()), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rb = ($urandom_range(0, 24) == 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      if (rb) do_rollback();
      if (ls_q.size() == 0 && $urandom_range(0, 1) == 1) begin
        wr = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        size = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : 3'($urandom_range(0, 7));
        r = $urandom_range(0, 3);
        addr = (r == 0) ? 32'h30000 + 32'($urandom_range(0, 15)) :
               (r == 3) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) :
                          32'h2000 + 32'($urandom_range(0, 63));
        issue_ls(wr, size, addr, $urandom, rb);
      end
      if (if_q.size() == 0 && $urandom_range(0, 2) == 0)
        issue_if(32'h1000 + 32'($urandom_range(0, 255)), rb);
    end

    tick();
    io_buffer_full = 1'b0;
    for (int c = 0; c < 200 && (ls_q.size() + if_q.size() + wr_q.size()) != 0; c++) tick();
    check("drain_ls", 32'(ls_q.size()), 32'd0);
    check("drain_if", 32'(if_q.size()), 32'd0);
    check("drain_wr", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide RAM/IO port; shares it between the instruction fetcher and the load/store execution unit.
- Latches single-cycle requests from each side and picks one with fixed priority (load/store over fetch).
- Sequences multi-byte transfers one byte per cycle and returns assembled little-endian data with a one-cycle finish pulse.
- Honours pipeline rollback (drops loads/fetches, never stores) and IO-buffer back-pressure.

Parameters:
- ADDR_W, 32, address width.
- IO_SEL, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low = freeze all state
- ls_en  in  1  one-cycle request pulse from load/store unit
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data, low bytes used
- ls_size  in  3  bytes to transfer: 1, 2 or 4
- ls_wr  in  1  1 = store, 0 = load
- ls_finish  out  1  one-cycle done pulse
- ls_rdata  out  32  load data, zero-filled above size
- if_en  in  1  one-cycle fetch request pulse
- if_addr  in  ADDR_W  fetch address, always 4 bytes
- if_finish  out  1  one-cycle done pulse
- if_inst  out  32  fetched word
- rollback  in  1  flush from ROB
- io_buffer_full  in  1  IO write sink cannot accept a byte
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write this cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; pending latches clear; all outputs 0.
- rdy=0: no register changes; mem_wr output forced 0.
- Request latches: ls_en / if_en capture addr, size, data and direction into ls_pend / if_pend. A latch is held until its operation starts or is dropped.
- Arbitration: only in IDLE. ls_pend beats if_pend. A request pulse arriving in the same IDLE cycle is eligible immediately. The granted latch clears on start.
- States:
  - IDLE
  - LS_RD: load
  - LS_WR: store
  - IF_RD: fetch
- Read of N bytes (N = size, or 4 for fetch):
  - mem_a = addr+i in cycles i = 0..N-1 after entry.
  - Byte i is taken from mem_din in cycle i+1 into bits [8i+7:8i].
  - In cycle N, finish=1 and data is valid for that single cycle; state returns to IDLE.
  - Read latency is N+1 cycles from entry.
- Write of N bytes: in cycle i, mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - After byte N-1, the next cycle asserts ls_finish with mem_wr=0, then IDLE.
  - If addr[17:16]==IO_SEL and io_buffer_full=1, the byte is held (mem_wr=0) and retried next cycle. A stall never skips or repeats a byte.
- Finish pulse: exactly one cycle. ls_rdata and if_inst hold their last value afterwards. IDLE after finish takes one cycle before the next start.
- Illegal ls_size (0, 3, 5-7): treated as 4.
- Rollback, in the cycle it is asserted:
  - An active LS_RD or IF_RD aborts: state goes to IDLE, no finish pulse, partial data discarded.
  - ls_pend holding a load is cleared; if_pend is cleared.
  - ls_en / if_en in that same cycle are ignored unless it is a store.
  - LS_WR and a pending store always complete, with finish.
- Simultaneous ls_en and if_en both latch. The load/store runs first; the fetch follows after one IDLE bubble.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared defines header holds:
  - RAM_LOAD / RAM_STORE.
  - Size codes SIZE_B=1, SIZE_H=2, SIZE_W=4.
  - IO_SEL.
  - State encodings STATE_IDLE / LS_RD / LS_WR / IF_RD (2-bit).
- No sub-module needed; single FSM with a 3-bit byte counter and 32-bit assembly register.

Test Plan:
- LW at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 over 4 cycles; ls_finish exactly 5 cycles after start; ls_rdata=0x44332211.
- LH at 0x201, bytes AA BB -> ls_rdata=0x0000BBAA; finish at cycle 2; no further mem_a activity.
- SW 0xDEADBEEF to 0x30000 with io_buffer_full high for 3 cycles from byte 1 -> bytes EF, BE, AD, DE each written once; mem_wr low during the stall; one ls_finish.
- ls_en (LB 0x40) and if_en (0x1000) in the same cycle -> ls_finish with byte first; if_finish later with 0x1000..0x1003 assembled; never both finish in one cycle.
- Fetch in progress at byte 2, then rollback -> state IDLE next cycle, no if_finish, pending load dropped; SB issued with rollback -> still written and ls_finish pulsed.
- rst low mid LS_WR -> mem_wr=0 immediately; all outputs 0; after release, a new LW completes normally.
